// File: rtl/strip_index_unit.sv
// First-fit strip allocator: keeps a 16-entry occupancy/strike table fed by the
// write-to-index pipeline and scans it one strip per cycle for a placement request.
module strip_index_unit #(
   parameter logic [7:0] STRIP_WIDTH  = 8'd200,
   parameter logic [3:0] STRIKE_LIMIT = 4'd8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] strip_ID_in,
   input  logic [7:0] occupied_width_in,
   input  logic [3:0] strike_in,
   input  logic       req_valid,
   input  logic [7:0] req_width,
   output logic       req_ready,
   output logic       idx_valid,
   input  logic       idx_ready,
   output logic       idx_found,
   output logic [3:0] idx_strip_ID,
   output logic [7:0] idx_free_width
);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t     state_reg;
   logic [3:0] ptr_reg;
   logic [7:0] width_reg;
   logic       found_reg;
   logic [3:0] strip_reg;
   logic [7:0] free_reg;

   logic [7:0] occ_reg    [16];
   logic [3:0] strike_reg [16];

   // The table is rewritten every cycle; holding the same record is harmless.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_table
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               occ_reg[gi]    <= 8'd0;
               strike_reg[gi] <= 4'd0;
            end else if (strip_ID_in == 4'(gi)) begin
               occ_reg[gi]    <= occupied_width_in;
               strike_reg[gi] <= strike_in;
            end
         end
      end
   endgenerate

   logic [7:0] cur_occ;
   logic [7:0] cur_free;
   logic       cur_elig;

   always_comb begin
      cur_occ  = occ_reg[ptr_reg];
      cur_free = (cur_occ < STRIP_WIDTH) ? (STRIP_WIDTH - cur_occ) : 8'd0;
      cur_elig = (strike_reg[ptr_reg] < STRIKE_LIMIT) && (cur_free >= width_reg);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         ptr_reg   <= 4'd0;
         width_reg <= 8'd0;
         found_reg <= 1'b0;
         strip_reg <= 4'd0;
         free_reg  <= 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  width_reg <= req_width;
                  ptr_reg   <= 4'd0;
                  state_reg <= SCAN;
               end
            end
            SCAN: begin
               if (cur_elig) begin
                  found_reg <= 1'b1;
                  strip_reg <= ptr_reg;
                  free_reg  <= cur_free;
                  state_reg <= RESP;
               end else if (ptr_reg == 4'd15) begin
                  found_reg <= 1'b0;
                  strip_reg <= 4'd0;
                  free_reg  <= 8'd0;
                  state_reg <= RESP;
               end else begin
                  ptr_reg <= ptr_reg + 4'd1;
               end
            end
            RESP: begin
               if (idx_ready) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req_ready      = (state_reg == IDLE) && !rst;
   assign idx_valid      = (state_reg == RESP);
   assign idx_found      = found_reg;
   assign idx_strip_ID   = strip_reg;
   assign idx_free_width = free_reg;

endmodule

// File: tb/tb_strip_index_unit.sv
// Randomized scoreboard bench for strip_index_unit: driver predicts each result from a
// table model and the planned update stream; a monitor checks results on handshake.
module tb_strip_index_unit;
   localparam int SW = 200;
   localparam int SL = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] strip_ID_in = '0;
   logic [7:0] occupied_width_in = '0;
   logic [3:0] strike_in = '0;
   logic       req_valid = 1'b0;
   logic [7:0] req_width = '0;
   logic       req_ready;
   logic       idx_valid;
   logic       idx_ready = 1'b0;
   logic       idx_found;
   logic [3:0] idx_strip_ID;
   logic [7:0] idx_free_width;

   strip_index_unit dut (
      .clk(clk), .rst(rst),
      .strip_ID_in(strip_ID_in), .occupied_width_in(occupied_width_in), .strike_in(strike_in),
      .req_valid(req_valid), .req_width(req_width), .req_ready(req_ready),
      .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_found(idx_found),
      .idx_strip_ID(idx_strip_ID), .idx_free_width(idx_free_width)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int found;
      int id;
      int free;
      int acc;
      int lat;
   } exp_t;
   exp_t sb[$];

   int m_occ[16];
   int m_str[16];

   function automatic int free_of(int occ);
      return (occ < SW) ? (SW - occ) : 0;
   endfunction

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic drive_upd(int id, int occ, int str);
      strip_ID_in       = 4'(id);
      occupied_width_in = 8'(occ);
      strike_in         = 4'(str);
      m_occ[id] = occ;
      m_str[id] = str;
   endtask

   task automatic set_entry(int id, int occ, int str);
      drive_upd(id, occ, str);
      @(posedge clk); #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         m_occ[i] = 0;
         m_str[i] = 0;
      end
   endtask

   // Strip j is examined after the updates of scan cycles 0..j have landed.
   task automatic do_txn(int w, bit rnd);
      int uid[16], uocc[16], ustr[16];
      int t_occ[16], t_str[16];
      exp_t e;
      t_occ = m_occ;
      t_str = m_str;
      e.found = 0; e.id = 0; e.free = 0;
      for (int j = 0; j < 16; j++) begin
         if (rnd) begin
            uid[j]  = $urandom_range(0, 15);
            uocc[j] = $urandom_range(0, 255);
            ustr[j] = $urandom_range(0, 15);
         end else begin
            uid[j]  = 0;
            uocc[j] = t_occ[0];
            ustr[j] = t_str[0];
         end
         t_occ[uid[j]] = uocc[j];
         t_str[uid[j]] = ustr[j];
         if (e.found == 0 && t_str[j] < SL && free_of(t_occ[j]) >= w) begin
            e.found = 1;
            e.id    = j;
            e.free  = free_of(t_occ[j]);
         end
      end
      e.lat = (e.found != 0) ? e.id + 1 : 16;
      e.acc = cyc + 1;
      sb.push_back(e);
      $display("TXN width=%0d expect found=%0d strip=%0d free=%0d lat=%0d",
               w, e.found, e.id, e.free, e.lat);
      for (int j = 0; j < 16; j++) begin
         drive_upd(uid[j], uocc[j], ustr[j]);
         req_valid = (j == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         req_width = (j == 0) ? 8'(w) : 8'($urandom);
         @(posedge clk); #1;
         chk("req_ready_busy", int'(req_ready), 0);
      end
      req_valid = 1'b0;
      idx_ready = 1'b1;
      for (int n = 0; n < 40 && !req_ready; n++) begin
         @(posedge clk); #1;
      end
      chk("return_idle", int'(req_ready), 1);
      idx_ready = 1'b0;
   endtask

   exp_t mon_e;
   bit   prev_v = 0;
   bit   have = 0;
   int   cap_f, cap_id, cap_free, rise_cyc;

   always @(negedge clk) begin
      if (rst) begin
         prev_v = 0;
         have   = 0;
      end else begin
         if (idx_valid) chk("req_ready_in_resp", int'(req_ready), 0);
         if (idx_valid && !prev_v) begin
            if (sb.size() == 0) begin
               chk("unexpected_idx_valid", 1, 0);
            end else begin
               have     = 1;
               rise_cyc = cyc;
               cap_f    = idx_found;
               cap_id   = idx_strip_ID;
               cap_free = idx_free_width;
            end
         end else if (idx_valid && have) begin
            chk("hold_found", int'(idx_found), cap_f);
            chk("hold_strip", int'(idx_strip_ID), cap_id);
            chk("hold_free", int'(idx_free_width), cap_free);
         end
         if (idx_valid && idx_ready && have) begin
            mon_e = sb.pop_front();
            chk("found", int'(idx_found), mon_e.found);
            chk("strip", int'(idx_strip_ID), mon_e.id);
            chk("free", int'(idx_free_width), mon_e.free);
            chk("latency", rise_cyc - mon_e.acc, mon_e.lat);
            have = 0;
         end
         prev_v = idx_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_idx_valid", int'(idx_valid), 0);
      chk("rst_idx_found", int'(idx_found), 0);
      chk("rst_idx_strip", int'(idx_strip_ID), 0);
      chk("rst_idx_free", int'(idx_free_width), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      rst = 1'b0;
      drive_upd(0, 0, 0);

      do_txn(50, 0);                                  // fresh table: strip 0, free 200

      set_entry(0, 180, 0);
      set_entry(1, 100, 2);
      do_txn(50, 0);                                  // strip 1, free 100

      set_entry(1, 0, 0);
      set_entry(0, 0, 8);
      do_txn(10, 0);                                  // strike-limited strip 0 skipped

      for (int i = 0; i < 16; i++) set_entry(i, (i == 3) ? 250 : 200, 0);
      do_txn(1, 0);                                   // nothing fits
      do_txn(0, 0);                                   // zero width matches full strip 0

      // Abort a scan with reset at pointer 7.
      set_entry(0, 190, 0);
      req_valid = 1'b1;
      req_width = 8'd255;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("abort_idx_valid", int'(idx_valid), 0);
      chk("abort_req_ready", int'(req_ready), 0);
      chk("abort_idx_found", int'(idx_found), 0);
      strip_ID_in = 4'd0; occupied_width_in = 8'd250; strike_in = 4'd9;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_hold_valid", int'(idx_valid), 0);
      end
      rst = 1'b0;
      clear_model();
      drive_upd(5, 0, 0);
      do_txn(10, 0);                                  // cleared table: strip 0, free 200

      repeat (40) do_txn($urandom_range(0, 210), 1);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/strip_index_unit.md
STRIP_INDEX_UNIT -- requirements
Module: strip_index_unit

Interface
REQ-001 The block SHALL have parameter STRIP_WIDTH, default 8'd200, meaning the capacity of one strip in width units.
REQ-002 The block SHALL have parameter STRIKE_LIMIT, default 4'd8, meaning a strip whose strike is at or above this value is ineligible.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- strip_ID_in  in  4  strip number of the table-update record from the write-to-index pipeline register.
- occupied_width_in  in  8  new occupied width for strip_ID_in.
- strike_in  in  4  new strike count for strip_ID_in.
- req_valid  in  1  placement request present.
- req_width  in  8  width the program needs.
- req_ready  out  1  block can accept a request.
- idx_valid  out  1  result present.
- idx_ready  in  1  consumer takes the result.
- idx_found  out  1  an eligible strip exists.
- idx_strip_ID  out  4  selected strip.
- idx_free_width  out  8  free width of the selected strip.

Function
REQ-004 The block SHALL hold a 16-entry table; each entry is {occupied[7:0], strike[3:0]}.
REQ-005 The block SHALL write entry[strip_ID_in] <= {occupied_width_in, strike_in} on every clock edge with rst low; no enable is needed because repeated writes of identical data are idempotent.
REQ-006 The block SHALL compute free width as STRIP_WIDTH - occupied when occupied < STRIP_WIDTH, else 0; there is no wrap-around.
REQ-007 A strip SHALL be eligible when strike < STRIKE_LIMIT and free >= req_width, using an unsigned 8-bit compare.
REQ-008 The block SHALL implement an FSM with states IDLE, SCAN and RESP.
REQ-009 req_ready SHALL equal (state==IDLE) AND NOT rst.
REQ-010 In IDLE, on req_valid && req_ready, the block SHALL latch req_width, clear the scan pointer to 0 and enter SCAN.
REQ-011 In SCAN, the block SHALL examine exactly one strip per cycle, at the pointer, in ascending order 0..15 (first-fit).
REQ-012 SCAN SHALL read the table value registered before the current edge; an update to the strip being examined in the same cycle is not seen by that examination.
REQ-013 On the first eligible strip k, the block SHALL register idx_found=1, idx_strip_ID=k and idx_free_width=free(k), then enter RESP.
REQ-014 If strip 15 is ineligible, the block SHALL register idx_found=0, idx_strip_ID=0 and idx_free_width=0, then enter RESP.
REQ-015 Latency from the accept edge to idx_valid high SHALL be k+1 cycles when strip k is found, and 16 cycles when no strip is found.
REQ-016 idx_valid SHALL be 1 exactly when state==RESP.
REQ-017 On idx_ready in RESP, the block SHALL return to IDLE; a new request is acceptable on the following cycle.
REQ-018 While idx_valid && !idx_ready, idx_found, idx_strip_ID and idx_free_width SHALL hold stable.
REQ-019 The block SHALL ignore req_valid outside IDLE.
REQ-020 With req_width=0, the first strip with strike < STRIKE_LIMIT SHALL match, even when its free width is 0.
REQ-021 Table updates SHALL continue in every state, including SCAN and RESP.

Reset
REQ-022 On rst=1, the block SHALL asynchronously clear every table entry to 0, set state=IDLE and clear the pointer and latched width.
REQ-023 On rst=1, the block SHALL drive idx_valid=0, idx_found=0, idx_strip_ID=0, idx_free_width=0 and req_ready=0.
REQ-024 Reset asserted mid-SCAN or mid-RESP SHALL abandon the operation; no idx_valid is produced for it.
REQ-025 With rst=1, the block SHALL ignore all table-update inputs.
REQ-026 The first request SHALL be acceptable in the first cycle after rst falls.

Verification
REQ-027 Fresh reset, req_width=50 -> idx_valid 1 cycle after accept; found=1, strip 0, free 200.
REQ-028 Strip 0 occupied=180 and strip 1 occupied=100 strike=2 (both applied via the table-update inputs), req_width=50 -> strip 1, free 100, latency 2.
REQ-029 Strip 0 strike=8 occupied=0, req_width=10 -> strip 0 skipped; strip 1, free 200.
REQ-030 All strips occupied=200 (strip 3 occupied=250), req_width=1 -> found=0, latency 16; repeat with req_width=0 -> strip 0, free 0.
REQ-031 Result held with idx_ready=0 for 5 cycles and req_valid pulsed -> outputs stable, req_ready=0, request not taken; idx_ready=1 -> IDLE next cycle.
REQ-032 rst pulsed during SCAN at pointer 7 -> idx_valid never asserts; table reads 0; next request req_width=10 -> strip 0, free 200.
